// File: rtl/mem_port_arbiter_if.sv
// Request/response and memory-side signals shared by the fetch stage, load/store stage,
// the single-ported memory and the arbiter between them.
interface mem_port_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  if_req_valid;
  logic [ADDR_WIDTH-1:0] if_req_addr;
  logic                  if_req_ready;
  logic                  if_resp_valid;
  logic [DATA_WIDTH-1:0] if_resp_data;

  logic                  dm_req_valid;
  logic                  dm_req_write;
  logic [ADDR_WIDTH-1:0] dm_req_addr;
  logic [DATA_WIDTH-1:0] dm_req_wdata;
  logic                  dm_req_ready;
  logic                  dm_resp_valid;
  logic [DATA_WIDTH-1:0] dm_resp_data;

  logic                  mem_read_enable;
  logic                  mem_write_enable;
  logic [ADDR_WIDTH-1:0] mem_read_addr;
  logic [ADDR_WIDTH-1:0] mem_write_addr;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic [DATA_WIDTH-1:0] mem_read_data;

  // Arbiter view.
  modport slave (
    input  if_req_valid, if_req_addr, dm_req_valid, dm_req_write, dm_req_addr, dm_req_wdata,
           mem_read_data,
    output if_req_ready, if_resp_valid, if_resp_data, dm_req_ready, dm_resp_valid,
           dm_resp_data, mem_read_enable, mem_write_enable, mem_read_addr, mem_write_addr,
           mem_write_data
  );

  // Requester and memory view.
  modport master (
    output if_req_valid, if_req_addr, dm_req_valid, dm_req_write, dm_req_addr, dm_req_wdata,
           mem_read_data,
    input  if_req_ready, if_resp_valid, if_resp_data, dm_req_ready, dm_resp_valid,
           dm_resp_data, mem_read_enable, mem_write_enable, mem_read_addr, mem_write_addr,
           mem_write_data
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch (read-only) and load/store.
// Data side wins contention until fetch has lost STARVE_LIMIT times in a row.
module mem_port_arbiter #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned StW  = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned LatW = $clog2(READ_LATENCY) + 1;
  localparam logic [StW-1:0]  StarveMax = StW'(STARVE_LIMIT);
  localparam logic [LatW-1:0] LatInit   = LatW'(READ_LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [StW-1:0]        starve_q, starve_d;
  logic [LatW-1:0]       lat_q, lat_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic                  owner_dm_q, owner_dm_d;
  logic                  grant_if, grant_dm;

  always_comb begin
    grant_if = bus.if_req_valid && (!bus.dm_req_valid || (starve_q == StarveMax));
    grant_dm = bus.dm_req_valid && !grant_if;
  end

  always_comb begin
    state_d              = state_q;
    starve_d             = starve_q;
    lat_d                = lat_q;
    addr_d               = addr_q;
    wdata_d              = wdata_q;
    write_d              = write_q;
    owner_dm_d           = owner_dm_q;
    bus.if_req_ready     = 1'b0;
    bus.dm_req_ready     = 1'b0;
    bus.if_resp_valid    = 1'b0;
    bus.if_resp_data     = '0;
    bus.dm_resp_valid    = 1'b0;
    bus.dm_resp_data     = '0;
    bus.mem_read_enable  = 1'b0;
    bus.mem_write_enable = 1'b0;
    bus.mem_read_addr    = addr_q;
    bus.mem_write_addr   = addr_q;
    bus.mem_write_data   = wdata_q;

    unique case (state_q)
      StIdle: begin
        // Ready is combinational, so it must be masked while reset is held.
        if (!rst) begin
          bus.if_req_ready = grant_if;
          bus.dm_req_ready = grant_dm;
          if (grant_if) begin
            addr_d     = bus.if_req_addr;
            write_d    = 1'b0;
            owner_dm_d = 1'b0;
            starve_d   = '0;
            state_d    = StIssue;
          end else if (grant_dm) begin
            addr_d     = bus.dm_req_addr;
            wdata_d    = bus.dm_req_wdata;
            write_d    = bus.dm_req_write;
            owner_dm_d = 1'b1;
            if (bus.if_req_valid && (starve_q != StarveMax)) starve_d = starve_q + 1'b1;
            state_d    = StIssue;
          end
        end
      end
      StIssue: begin
        if (write_q) begin
          bus.mem_write_enable = 1'b1;
          bus.dm_resp_valid    = 1'b1;
          state_d              = StIdle;
        end else begin
          bus.mem_read_enable = 1'b1;
          if (READ_LATENCY == 1) begin
            state_d = StResp;
          end else begin
            lat_d   = LatInit;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (lat_q == LatW'(1)) state_d = StResp;
        else                   lat_d   = lat_q - 1'b1;
      end
      StResp: begin
        if (owner_dm_q) begin
          bus.dm_resp_valid = 1'b1;
          bus.dm_resp_data  = bus.mem_read_data;
        end else begin
          bus.if_resp_valid = 1'b1;
          bus.if_resp_data  = bus.mem_read_data;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      starve_q   <= '0;
      lat_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      owner_dm_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      lat_q      <= lat_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      owner_dm_q <= owner_dm_d;
    end
  end

endmodule
